// File: rtl/tx_word_arbiter.sv
// tx_word_arbiter
//   Round-robin scheduler sharing one DataSender/UART byte-serialiser path
//   between N_CH producers of WORD_W-bit words. The winning word is latched
//   onto sender_data, a one-cycle sender_start is issued, and byte_done pulses
//   are counted until BYTES_PER_WORD bytes have gone out.
//
// Optional feature: define TX_ARB_TIMEOUT_EN to build a per-byte watchdog.
//   The word is abandoned after TIMEOUT_CYCLES SEND cycles without byte_done,
//   and the sticky timeout_err flag is set. Without the macro timeout_err is 0.
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   req          per-channel request, held with stable data until ack
//   data_in      channel words, channel i at [i*WORD_W +: WORD_W]
//   ack          one-cycle pulse to the granted channel
//   sender_data  word presented to DataSender dataIn (held until next capture)
//   sender_start one-cycle pulse to DataSender transmission_started
//   byte_done    transmission_done from the byte transmitter
//   grant_idx    index of the channel currently or last served
//   busy         high from capture until the last byte_done is consumed
//   timeout_err  sticky watchdog flag
module tx_word_arbiter #(
    parameter int N_CH           = 4,
    parameter int WORD_W         = 40,
    parameter int BYTES_PER_WORD = 5,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_CH-1:0]          req,
    input  logic [N_CH*WORD_W-1:0]   data_in,
    output logic [N_CH-1:0]          ack,
    output logic [WORD_W-1:0]        sender_data,
    output logic                     sender_start,
    input  logic                     byte_done,
    output logic [$clog2(N_CH)-1:0]  grant_idx,
    output logic                     busy,
    output logic                     timeout_err
);

    localparam int IDX_W = $clog2(N_CH);
    localparam int CNT_W = $clog2(BYTES_PER_WORD + 1);
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BYTES_PER_WORD - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_SEND  = 2'd2;

    if (N_CH < 2 || N_CH > 8 || WORD_W != BYTES_PER_WORD * 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("tx_word_arbiter: illegal parameter combination");
    end

    logic [1:0]        state;
    logic [IDX_W-1:0]  last;
    logic [CNT_W-1:0]  byte_cnt;
    logic [IDX_W-1:0]  winner;
    logic [WORD_W-1:0] winner_word;

    // Scan last+N_CH down to last+1 so the candidate closest to last+1 is
    // written last and therefore wins; the just-served channel (offset N_CH)
    // ends up with the lowest priority.
    always_comb begin
        logic [IDX_W-1:0] cand;
        winner = last;
        cand   = last;
        for (int k = N_CH; k >= 1; k--) begin
            cand = IDX_W'((int'(last) + k) % N_CH);
            if (req[cand]) begin
                winner = cand;
            end
        end
        winner_word = data_in[winner*WORD_W +: WORD_W];
    end

`ifdef TX_ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    logic [TO_W-1:0] to_cnt;
    logic            timeout_q;
    assign timeout_err = timeout_q;
`else
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            ack          <= '0;
            sender_start <= 1'b0;
            sender_data  <= '0;
            grant_idx    <= '0;
            busy         <= 1'b0;
            byte_cnt     <= '0;
            last         <= IDX_W'(N_CH - 1);
`ifdef TX_ARB_TIMEOUT_EN
            to_cnt       <= '0;
            timeout_q    <= 1'b0;
`endif
        end else begin
            ack          <= '0;
            sender_start <= 1'b0;
            case (state)
                // IDLE -> START: capture the winner's word at the request edge
                ST_IDLE: begin
                    if (|req) begin
                        sender_data  <= winner_word;
                        grant_idx    <= winner;
                        busy         <= 1'b1;
                        ack[winner]  <= 1'b1;
                        sender_start <= 1'b1;
                        state        <= ST_START;
                    end
                end
                // START -> SEND: byte_done is deliberately ignored here
                ST_START: begin
                    byte_cnt <= '0;
                    state    <= ST_SEND;
`ifdef TX_ARB_TIMEOUT_EN
                    to_cnt   <= '0;
`endif
                end
                // SEND -> IDLE: after the final byte (or a watchdog expiry)
                ST_SEND: begin
                    if (byte_done) begin
                        if (byte_cnt == LAST_BYTE) begin
                            state    <= ST_IDLE;
                            busy     <= 1'b0;
                            last     <= grant_idx;
                            byte_cnt <= '0;
                        end else begin
                            byte_cnt <= byte_cnt + CNT_W'(1);
                        end
                    end
`ifdef TX_ARB_TIMEOUT_EN
                    if (byte_done) begin
                        to_cnt <= '0;
                    end else if (to_cnt == TO_LAST) begin
                        state     <= ST_IDLE;
                        busy      <= 1'b0;
                        last      <= grant_idx;
                        byte_cnt  <= '0;
                        to_cnt    <= '0;
                        timeout_q <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
`endif
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
